// File: rtl/cam_sccb_init_seq_if.sv
// SCCB write-request channel between the camera init sequencer (master)
// and the SCCB bus engine (slave).
interface cam_sccb_init_seq_if;
   logic        sccb_req;
   logic [15:0] sccb_reg_addr;
   logic [7:0]  sccb_wdata;
   logic        sccb_done;
   logic        sccb_nack;

   modport master (
      output sccb_req,
      output sccb_reg_addr,
      output sccb_wdata,
      input  sccb_done,
      input  sccb_nack
   );

   modport slave (
      input  sccb_req,
      input  sccb_reg_addr,
      input  sccb_wdata,
      output sccb_done,
      output sccb_nack
   );
endinterface

// File: rtl/cam_sccb_init_seq.sv
// Camera power-up and register-configuration sequencer.
// Cycles the camera enable GPIO, then walks a synchronous register ROM and
// issues one SCCB write per entry, with NACK retry, delay and end entries.
//
// state     | meaning
// IDLE      | reset state, waiting for start
// PWR_OFF   | enable GPIO held low
// PWR_ON    | enable GPIO high, sensor power-up wait
// FETCH     | ROM address presented, one cycle of ROM latency
// DECODE    | ROM word valid, branch on entry type
// WRITE     | SCCB request held until done
// RETRY     | one request-low cycle before re-issuing a NACKed entry
// WAIT_MS   | delay entry countdown
// DONE      | table completed, waiting for start
// ERROR     | entry failed after all retries, waiting for start
module cam_sccb_init_seq #(
   parameter int TBL_AW      = 6,
   parameter int PWR_OFF_CYC = 1000000,
   parameter int PWR_ON_CYC  = 2000000,
   parameter int MS_CYC      = 100000,
   parameter int MAX_RETRY   = 3
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   output logic                o_cam_gpio,
   output logic [TBL_AW-1:0]   o_tbl_addr,
   input  logic [23:0]         i_tbl_data,
   cam_sccb_init_seq_if.master sccb,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_error,
   output logic [TBL_AW-1:0]   o_err_index
);

   localparam int DLY_MAX = 255 * MS_CYC;
   localparam int CW_DLY  = $clog2(DLY_MAX + 1);
   localparam int CW_OFF  = $clog2(PWR_OFF_CYC + 1);
   localparam int CW_ON   = $clog2(PWR_ON_CYC + 1);
   localparam int CW_PWR  = (CW_OFF > CW_ON) ? CW_OFF : CW_ON;
   localparam int CW      = (CW_DLY > CW_PWR) ? CW_DLY : CW_PWR;
   localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_PWR_OFF, S_PWR_ON, S_FETCH, S_DECODE,
      S_WRITE, S_RETRY, S_WAIT_MS, S_DONE, S_ERROR
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CW-1:0]      r_cnt;
   logic [RW-1:0]      r_retry;
   logic [TBL_AW-1:0]  r_tbl_addr;
   logic [TBL_AW-1:0]  r_err_index;
   logic [15:0]        r_reg_addr;
   logic [7:0]         r_wdata;
   logic               r_gpio;

   logic [15:0]        w_entry_addr;
   logic [7:0]         w_entry_val;
   logic               w_cnt_tc;
   logic               w_last;
   logic               w_retry_max;
   logic               w_is_end;
   logic               w_is_delay;
   logic               w_req;
   logic               w_busy;
   logic               w_done;
   logic               w_error;

   assign w_entry_addr = i_tbl_data[23:8];
   assign w_entry_val  = i_tbl_data[7:0];
   assign w_cnt_tc     = (r_cnt == '0);
   assign w_last       = (r_tbl_addr == '1);
   assign w_retry_max  = (r_retry == RW'(MAX_RETRY));
   assign w_is_end     = (w_entry_addr == 16'hFFFF);
   assign w_is_delay   = (w_entry_addr == 16'hFFFE);

   // State register; reset overrides every other input.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode. The last table slot ends the sequence instead of wrapping.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: if (i_start) w_next = S_PWR_OFF;
         S_PWR_OFF: if (w_cnt_tc) w_next = S_PWR_ON;
         S_PWR_ON:  if (w_cnt_tc) w_next = S_FETCH;
         S_FETCH:   w_next = S_DECODE;
         S_DECODE: begin
            if (w_is_end)                w_next = S_DONE;
            else if (!w_is_delay)        w_next = S_WRITE;
            else if (w_entry_val != '0)  w_next = S_WAIT_MS;
            else                         w_next = w_last ? S_DONE : S_FETCH;
         end
         S_WRITE: begin
            if (sccb.sccb_done) begin
               if (!sccb.sccb_nack)  w_next = w_last ? S_DONE : S_FETCH;
               else if (w_retry_max) w_next = S_ERROR;
               else                  w_next = S_RETRY;
            end
         end
         S_RETRY:   w_next = S_WRITE;
         S_WAIT_MS: if (w_cnt_tc) w_next = w_last ? S_DONE : S_FETCH;
         default:   w_next = S_IDLE;
      endcase
   end

   // Datapath: timer down-counter, table pointer, retry count, latched entry, GPIO.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_retry     <= '0;
         r_tbl_addr  <= '0;
         r_err_index <= '0;
         r_reg_addr  <= '0;
         r_wdata     <= '0;
         r_gpio      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_start) begin
                  r_gpio     <= 1'b0;
                  r_tbl_addr <= '0;
                  r_retry    <= '0;
                  r_cnt      <= CW'(PWR_OFF_CYC - 1);
               end
            end
            S_PWR_OFF: begin
               if (w_cnt_tc) begin
                  r_gpio <= 1'b1;
                  r_cnt  <= CW'(PWR_ON_CYC - 1);
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_PWR_ON: if (!w_cnt_tc) r_cnt <= r_cnt - CW'(1);
            S_DECODE: begin
               if (!w_is_end && !w_is_delay) begin
                  r_reg_addr <= w_entry_addr;
                  r_wdata    <= w_entry_val;
               end else if (w_is_delay) begin
                  if (w_entry_val != '0)
                     r_cnt <= CW'(int'(w_entry_val) * MS_CYC - 1);
                  else if (!w_last)
                     r_tbl_addr <= r_tbl_addr + TBL_AW'(1);
               end
            end
            S_WRITE: begin
               if (sccb.sccb_done) begin
                  if (!sccb.sccb_nack) begin
                     r_retry <= '0;
                     if (!w_last) r_tbl_addr <= r_tbl_addr + TBL_AW'(1);
                  end else if (w_retry_max) begin
                     r_err_index <= r_tbl_addr;
                  end else begin
                     r_retry <= r_retry + RW'(1);
                  end
               end
            end
            S_WAIT_MS: begin
               if (w_cnt_tc) begin
                  if (!w_last) r_tbl_addr <= r_tbl_addr + TBL_AW'(1);
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // State-decoded outputs.
   always_comb begin
      w_req   = 1'b0;
      w_busy  = 1'b1;
      w_done  = 1'b0;
      w_error = 1'b0;
      case (r_state)
         S_IDLE:  w_busy = 1'b0;
         S_DONE:  begin w_busy = 1'b0; w_done  = 1'b1; end
         S_ERROR: begin w_busy = 1'b0; w_error = 1'b1; end
         S_WRITE: w_req = 1'b1;
         default: ;
      endcase
   end

   assign sccb.sccb_req      = w_req;
   assign sccb.sccb_reg_addr = r_reg_addr;
   assign sccb.sccb_wdata    = r_wdata;
   assign o_cam_gpio         = r_gpio;
   assign o_tbl_addr         = r_tbl_addr;
   assign o_busy             = w_busy;
   assign o_done             = w_done;
   assign o_error            = w_error;
   assign o_err_index        = r_err_index;

endmodule

// File: tb/tb_cam_sccb_init_seq.sv
// Bench for cam_sccb_init_seq: vector table of table/NACK scenarios plus
// hand-written power-up latency, reset-during-write and restart sequences.
module tb_cam_sccb_init_seq;
   localparam int AW  = 6;
   localparam int OFF = 10;
   localparam int ON  = 20;
   localparam int MS  = 100;
   localparam int MR  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          cam_gpio;
   logic [AW-1:0] tbl_addr;
   logic [23:0]   tbl_data;
   logic          busy, done, error;
   logic [AW-1:0] err_index;

   cam_sccb_init_seq_if sif();

   cam_sccb_init_seq #(
      .TBL_AW(AW), .PWR_OFF_CYC(OFF), .PWR_ON_CYC(ON), .MS_CYC(MS), .MAX_RETRY(MR)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_cam_gpio(cam_gpio),
      .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_data), .sccb(sif.master),
      .o_busy(busy), .o_done(done), .o_error(error), .o_err_index(err_index)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // synchronous ROM model
   logic [23:0] rom [64];
   always @(posedge clk) tbl_data <= rom[tbl_addr];

   // SCCB slave model: answers each request after 3 cycles, NACKs a chosen entry N times
   bit          slave_en = 1'b0;
   int          nack_idx = -1;
   int          nack_left = 0;
   int          sl_cnt = 0;
   int          low_cnt = 0;
   bit          prev_req = 1'b0;
   logic [23:0] wlog[$];
   int          gaps[$];
   logic [23:0] exp_w[$];
   int          exp_g[$];

   always @(negedge clk) begin
      if (rst) begin
         sif.sccb_done = 1'b0;
         sif.sccb_nack = 1'b0;
         sl_cnt = 0;
         low_cnt = 0;
         prev_req = 1'b0;
      end else begin
         if (sif.sccb_req && !prev_req && wlog.size() > 0) gaps.push_back(low_cnt);
         if (sif.sccb_done) begin
            sif.sccb_done = 1'b0;
            sif.sccb_nack = 1'b0;
            chk("req_low_after_done", 32'(sif.sccb_req), 32'd0);
         end else if (sif.sccb_req && slave_en) begin
            sl_cnt++;
            if (sl_cnt == 3) begin
               wlog.push_back({sif.sccb_reg_addr, sif.sccb_wdata});
               sif.sccb_nack = (int'(tbl_addr) == nack_idx) && (nack_left > 0);
               if (sif.sccb_nack) nack_left--;
               sif.sccb_done = 1'b1;
               sl_cnt = 0;
            end
         end
         if (sif.sccb_req) low_cnt = 0;
         else begin
            low_cnt++;
            sl_cnt = 0;
         end
         prev_req = sif.sccb_req;
      end
   end

   task automatic load_table(input int sel);
      for (int i = 0; i < 64; i++) rom[i] = 24'hFFFF00;
      case (sel)
         0: begin rom[0] = 24'h300882; rom[1] = 24'h010001; rom[2] = 24'hFFFF00; end
         1: begin rom[0] = 24'h300882; rom[1] = 24'h010001; rom[2] = 24'h382040; end
         2: begin
            rom[0] = 24'h300882; rom[1] = 24'hFFFE05; rom[2] = 24'h010001;
            rom[3] = 24'hFFFE00; rom[4] = 24'h382040;
         end
         default: for (int i = 0; i < 64; i++) rom[i] = {16'h4000 + 16'(i), 8'(i * 3)};
      endcase
   endtask

   // Reference walk: a fresh entry follows FETCH+DECODE (2 low cycles) plus 2+val*MS
   // per skipped delay entry; a retry follows a single low cycle.
   task automatic build_exp(input int nidx, input int nn);
      int pend = 0;
      bit first = 1'b1;
      int att;
      logic [23:0] e;
      exp_w.delete();
      exp_g.delete();
      for (int i = 0; i < 64; i++) begin
         e = rom[i];
         if (e[23:8] == 16'hFFFF) break;
         if (e[23:8] == 16'hFFFE) begin
            pend += 2 + int'(e[7:0]) * MS;
            continue;
         end
         att = 1;
         if (i == nidx) att = (nn > MR) ? MR + 1 : nn + 1;
         for (int k = 0; k < att; k++) begin
            exp_w.push_back(e);
            if (!first) exp_g.push_back((k > 0) ? 1 : 2 + pend);
            first = 1'b0;
         end
         pend = 0;
         if (i == nidx && nn > MR) break;
      end
   endtask

   task automatic prep(input int sel, input int nidx, input int nn);
      load_table(sel);
      build_exp(nidx, nn);
      nack_idx = nidx;
      nack_left = nn;
      wlog.delete();
      gaps.delete();
      slave_en = 1'b1;
   endtask

   task automatic wait_end(input string nm);
      int cyc = 0;
      while (!(done || error) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      if (!(done || error)) chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic check_log(input string nm);
      int n = (wlog.size() < exp_w.size()) ? wlog.size() : exp_w.size();
      for (int k = 0; k < n; k++) chk({nm, "_write"}, 32'(wlog[k]), 32'(exp_w[k]));
      chk({nm, "_gap_count"}, 32'(gaps.size()), 32'(exp_g.size()));
      n = (gaps.size() < exp_g.size()) ? gaps.size() : exp_g.size();
      for (int k = 0; k < n; k++) chk({nm, "_gap"}, 32'(gaps[k]), 32'(exp_g[k]));
   endtask

   typedef struct {
      string name;
      int    sel;
      int    nidx;
      int    nn;
      int    exp_writes;
      bit    exp_done;
      bit    exp_error;
      int    exp_err;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v);
      prep(v.sel, v.nidx, v.nn);
      pulse_start();
      wait_end(v.name);
      @(negedge clk);
      chk({v.name, "_done"},   32'(done),     32'(v.exp_done));
      chk({v.name, "_error"},  32'(error),    32'(v.exp_error));
      chk({v.name, "_busy"},   32'(busy),     32'd0);
      chk({v.name, "_req"},    32'(sif.sccb_req), 32'd0);
      chk({v.name, "_gpio"},   32'(cam_gpio), 32'd1);
      chk({v.name, "_writes"}, 32'(wlog.size()), 32'(v.exp_writes));
      if (v.exp_error) chk({v.name, "_err_index"}, 32'(err_index), 32'(v.exp_err));
      check_log(v.name);
   endtask

   initial begin
      int req_edge;
      rst = 1'b1;
      start = 1'b0;
      load_table(0);

      vecs[0] = '{"t2_all_ack",     0, -1, 0,  2, 1'b1, 1'b0, 0};
      vecs[1] = '{"t3_nack2",       0,  1, 2,  4, 1'b1, 1'b0, 0};
      vecs[2] = '{"t4_nack4_e2",    1,  2, 4,  6, 1'b0, 1'b1, 2};
      vecs[3] = '{"nack3_e0_ok",    1,  0, 3,  6, 1'b1, 1'b0, 0};
      vecs[4] = '{"nack4_e0_err",   1,  0, 4,  4, 1'b0, 1'b1, 0};
      vecs[5] = '{"t5_delay",       2, -1, 0,  3, 1'b1, 1'b0, 0};
      vecs[6] = '{"wrap_64",        3, -1, 0, 64, 1'b1, 1'b0, 0};
      vecs[7] = '{"nack1_e1",       1,  1, 1,  4, 1'b1, 1'b0, 0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gpio", 32'(cam_gpio), 0);
      chk("rst_req",  32'(sif.sccb_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_tbl_addr", 32'(tbl_addr), 0);
      chk("rst_err_index", 32'(err_index), 0);
      chk("rst_reg_addr", 32'(sif.sccb_reg_addr), 0);
      chk("rst_wdata", 32'(sif.sccb_wdata), 0);
      @(negedge clk) rst = 1'b0;

      // T1: gpio low for OFF cycles, first request OFF+ON+3 cycles after start
      prep(0, -1, 0);
      @(negedge clk) start = 1'b1;
      req_edge = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) start = 1'b0;
         if (e == 1) chk("t1_busy", 32'(busy), 1);
         if (e <= OFF) chk("t1_gpio_low", 32'(cam_gpio), 0);
         if (e == OFF + 1) chk("t1_gpio_high", 32'(cam_gpio), 1);
         if (sif.sccb_req && req_edge < 0) req_edge = e;
      end
      chk("t1_req_latency", 32'(req_edge), 32'(OFF + ON + 3));
      wait_end("t1");
      chk("t1_done", 32'(done), 1);

      // table-driven scenarios
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // T6: error state, then restart, reset while WRITE holds request, reset beats start
      run_vec(vecs[2]);
      prep(0, -1, 0);
      slave_en = 1'b0;
      pulse_start();
      for (int c = 0; c < 100 && !sif.sccb_req; c++) @(negedge clk);
      chk("t6_req_up", 32'(sif.sccb_req), 1);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_rst_req",       32'(sif.sccb_req), 0);
      chk("t6_rst_gpio",      32'(cam_gpio), 0);
      chk("t6_rst_busy",      32'(busy), 0);
      chk("t6_rst_done",      32'(done), 0);
      chk("t6_rst_error",     32'(error), 0);
      chk("t6_rst_tbl_addr",  32'(tbl_addr), 0);
      chk("t6_rst_err_index", 32'(err_index), 0);
      chk("t6_rst_reg_addr",  32'(sif.sccb_reg_addr), 0);
      chk("t6_rst_wdata",     32'(sif.sccb_wdata), 0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      slave_en = 1'b1;

      // start while busy must not restart the power sequence
      prep(0, -1, 0);
      @(negedge clk) start = 1'b1;
      req_edge = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (e == 1 || e == 16) start = 1'b0;
         if (e == 15) start = 1'b1;
         if (sif.sccb_req && req_edge < 0) req_edge = e;
      end
      chk("t6_busy_start_ignored", 32'(req_edge), 32'(OFF + ON + 3));
      wait_end("t6_seq");
      chk("t6_seq_done", 32'(done), 1);
      chk("t6_seq_writes", 32'(wlog.size()), 2);

      // start after done replays the table from index 0
      run_vec(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
